load_store_unit: RTL and testbench

// - Memory-access stage downstream of the datapath ALU: takes the effective address and store data,

---
 rtl/load_store_unit.sv | 207 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage issuing SB/SH/SW/LB/LH/LW/LBU/LHU over a req/ack handshake.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into an err pulse.
module load_store_unit #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [3:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   state_t            state_r, state_s;
   logic [TMR_W-1:0]  timer_r, timer_s;
   logic [3:0]        op_r, op_s;
   logic [1:0]        lo_r, lo_s;
   logic              busy_s, done_s, err_s, mem_req_s, mem_we_s;
   logic [3:0]        mem_be_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic [31:0]       mem_wdata_s, rdata_s;

   function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] be;
      case (size)
         2'b00:   be = 4'b0001 << lo;
         2'b01:   be = 4'b0011 << {lo[1], 1'b0};
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wd);
      logic [31:0] d;
      case (size)
         2'b00:   d = {4{wd[7:0]}};
         2'b01:   d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

   // Half loads use only lo[1]; word loads ignore the lane and the unsigned flag.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic uns, input logic [1:0] lo);
      logic [31:0] sh;
      logic [31:0] res;
      case (size)
         2'b00: begin
            sh  = word >> {lo, 3'b000};
            res = {{24{~uns & sh[7]}}, sh[7:0]};
         end
         2'b01: begin
            sh  = word >> {lo[1], 4'b0000};
            res = {{16{~uns & sh[15]}}, sh[15:0]};
         end
         default: begin
            sh  = word;
            res = sh;
         end
      endcase
      return res;
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic m;
      case (size)
         2'b01:   m = lo[0];
         2'b10:   m = (lo != 2'b00);
         default: m = 1'b0;
      endcase
      return m;
   endfunction
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and next-output decode
   always_comb begin
      state_s     = state_r;
      timer_s     = timer_r;
      op_s        = op_r;
      lo_s        = lo_r;
      done_s      = 1'b0;
      err_s       = 1'b0;
      mem_req_s   = mem_req;
      mem_we_s    = mem_we;
      mem_be_s    = mem_be;
      mem_addr_s  = mem_addr;
      mem_wdata_s = mem_wdata;
      rdata_s     = rdata;
      case (state_r)
         ST_IDLE: begin
            mem_req_s = 1'b0;
            if (start) begin
               if (op[1:0] == 2'b11) begin
                  err_s = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
               end else if (misaligned(op[1:0], addr[1:0])) begin
                  err_s = 1'b1;
`endif
               end else begin
                  state_s     = ST_REQ;
                  timer_s     = '0;
                  op_s        = op;
                  lo_s        = addr[1:0];
                  mem_req_s   = 1'b1;
                  mem_we_s    = op[3];
                  mem_be_s    = lane_enables(op[1:0], addr[1:0]);
                  mem_addr_s  = {addr[ADDR_W-1:2], 2'b00};
                  mem_wdata_s = lane_replicate(op[1:0], wdata);
               end
            end else begin
               op_s = op_r;
            end
         end
         ST_REQ: begin
            // An ack arriving on the expiry cycle still counts as success.
            if (mem_ack) begin
               state_s   = ST_RESP;
               mem_req_s = 1'b0;
               done_s    = 1'b1;
               if (!op_r[3]) begin
                  rdata_s = load_extend(mem_rdata, op_r[1:0], op_r[2], lo_r);
               end else begin
                  rdata_s = rdata;
               end
            end else if (timer_r == TMR_W'(TIMEOUT - 1)) begin
               state_s   = ST_RESP;
               mem_req_s = 1'b0;
               err_s     = 1'b1;
            end else begin
               timer_s = timer_r + TMR_W'(1);
            end
         end
         ST_RESP: begin
            state_s   = ST_IDLE;
            mem_req_s = 1'b0;
         end
         default: begin
            state_s   = ST_IDLE;
            mem_req_s = 1'b0;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // Registered outputs and latched access context
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timer_r   <= '0;
         op_r      <= 4'b0000;
         lo_r      <= 2'b00;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= 4'b0000;
         mem_addr  <= '0;
         mem_wdata <= 32'h0000_0000;
         rdata     <= 32'h0000_0000;
      end else begin
         timer_r   <= timer_s;
         op_r      <= op_s;
         lo_r      <= lo_s;
         busy      <= busy_s;
         done      <= done_s;
         err       <= err_s;
         mem_req   <= mem_req_s;
         mem_we    <= mem_we_s;
         mem_be    <= mem_be_s;
         mem_addr  <= mem_addr_s;
         mem_wdata <= mem_wdata_s;
         rdata     <= rdata_s;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, randomized memory responder.
module tb_load_store_unit;
   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  op = 4'b0000;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        busy, done, err, mem_req, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   typedef struct {
      bit          is_err;
      bit          is_store;
      logic [31:0] rdata;
      logic [31:0] maddr;
      logic [31:0] wd;
      logic [3:0]  be;
      int          req_cycles;
      int          end_cyc;
   } exp_t;

   exp_t        q[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          completed = 0;
   int          cyc = 0;
   int          req_cnt = 0;
   int          wait_cnt = 0;
   int          ack_delay = 0;
   bit          no_ack = 1'b0;
   logic [7:0]  ref_bytes[64];
   logic [31:0] mem_words[16];
   logic [31:0] model_rdata = 32'h0;

   load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .err(err), .rdata(rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string detail);
      vectors++;
      miscompares++;
      $display("FAIL %s: %s", name, detail);
   endtask

   // Reference model: byte-addressed memory, sizes as byte counts, alignment by rounding down.
   task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] wd,
                        input int delay, input bit noack, output exp_t e);
      int n, lo, base, w;
      logic [31:0] v;
      e.is_err = 1'b0;
      e.is_store = o[3];
      e.rdata = model_rdata;
      e.maddr = a & 32'hFFFF_FFFC;
      e.wd = 32'h0;
      e.be = 4'b0000;
      e.req_cycles = delay + 1;
      e.end_cyc = 0;
      if (o[1:0] == 2'b11) begin
         e.is_err = 1'b1;
         e.req_cycles = 0;
         return;
      end
      n = 1 << o[1:0];
      lo = int'(a[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
      if (lo % n != 0) begin
         e.is_err = 1'b1;
         e.req_cycles = 0;
         return;
      end
`endif
      base = lo - (lo % n);
      w = int'(a[5:2]);
      for (int k = 0; k < n; k++) e.be[base + k] = 1'b1;
      for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = wd[8*(i % n) +: 8];
      if (noack) begin
         e.is_err = 1'b1;
         e.req_cycles = TIMEOUT;
         return;
      end
      if (o[3]) begin
         for (int k = 0; k < n; k++) ref_bytes[4*w + base + k] = wd[8*k +: 8];
      end else begin
         v = 32'h0;
         for (int k = 0; k < n; k++) v = v | (32'(ref_bytes[4*w + base + k]) << (8*k));
         if (!o[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
         model_rdata = v;
         e.rdata = v;
      end
   endtask

   // Memory responder: acks after ack_delay request cycles, also throws stray acks while idle.
   initial begin
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            if (!no_ack && wait_cnt == ack_delay) begin
               mem_ack = 1'b1;
               mem_rdata = mem_words[mem_addr[5:2]];
               if (mem_we)
                  for (int i = 0; i < 4; i++)
                     if (mem_be[i]) mem_words[mem_addr[5:2]][8*i +: 8] = mem_wdata[8*i +: 8];
            end else begin
               mem_ack = 1'b0;
               mem_rdata = $urandom;
            end
            wait_cnt++;
         end else begin
            wait_cnt = 0;
            mem_ack = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
         end
      end
   end

   // Monitor: checks request fields and completions against the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            req_cnt = 0;
         end else begin
            if (mem_req) begin
               req_cnt++;
               if (q.size() == 0) begin
                  fail("req_unexpected", $sformatf("mem_req=1 addr=%h, expected no request", mem_addr));
               end else begin
                  e = q[0];
                  check("mem_addr", mem_addr, e.maddr);
                  check("mem_be", 32'(mem_be), 32'(e.be));
                  check_bit("mem_we", mem_we, e.is_store);
                  if (e.is_store) check("mem_wdata", mem_wdata, e.wd);
               end
            end
            if (done || err) begin
               if (q.size() == 0) begin
                  fail("completion_unexpected", $sformatf("done=%b err=%b, expected none", done, err));
               end else begin
                  e = q.pop_front();
                  check_bit("done", done, !e.is_err);
                  check_bit("err", err, e.is_err);
                  check_bit("busy_at_end", busy, e.req_cycles != 0);
                  check("rdata", rdata, e.rdata);
                  check("req_cycles", req_cnt, e.req_cycles);
                  check("end_cycle", cyc, e.end_cyc);
               end
               req_cnt = 0;
               completed++;
            end
         end
      end
   end

   task automatic wait_completion(input int c0);
      int k;
      k = 0;
      while (completed == c0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (completed == c0) begin
         fail("completion_timeout", "no done/err within 200 cycles, expected one");
         q.delete();
      end
   endtask

   task automatic access(input logic [3:0] o, input logic [31:0] a, input logic [31:0] wd,
                         input int delay, input bit noack);
      exp_t e;
      int c0;
      @(negedge clk);
      model(o, a, wd, delay, noack, e);
      e.end_cyc = cyc + 1 + e.req_cycles;
      q.push_back(e);
      ack_delay = delay;
      no_ack = noack;
      op = o;
      addr = a;
      wdata = wd;
      start = 1'b1;
      c0 = completed;
      @(negedge clk);
      start = 1'b0;
      op = 4'($urandom);
      addr = $urandom;
      wdata = $urandom;
      wait_completion(c0);
      @(posedge clk);
      #1;
      check_bit("busy_after_end", busy, 1'b0);
   endtask

   initial begin
      exp_t e;
      int c0;
      for (int w = 0; w < 16; w++) begin
         mem_words[w] = $urandom;
         for (int k = 0; k < 4; k++) ref_bytes[4*w + k] = mem_words[w][8*k +: 8];
      end
      repeat (3) @(negedge clk);
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_done", done, 1'b0);
      check_bit("rst_err", err, 1'b0);
      check_bit("rst_mem_req", mem_req, 1'b0);
      check_bit("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_be", 32'(mem_be), 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      rst_n = 1'b1;

      access(4'b1000, 32'h0000_0013, 32'h0000_00AB, 0, 1'b0);
      access(4'b1001, 32'h0000_0022, 32'h0000_8001, 1, 1'b0);
      access(4'b0001, 32'h0000_0022, 32'h0, 0, 1'b0);
      check("lh_value", rdata, 32'hFFFF_8001);
      access(4'b0101, 32'h0000_0022, 32'h0, 2, 1'b0);
      check("lhu_value", rdata, 32'h0000_8001);
      access(4'b1010, 32'h0000_0004, 32'h1234_80FF, 0, 1'b0);
      access(4'b0000, 32'h0000_0004, 32'h0, 0, 1'b0);
      check("lb_value", rdata, 32'hFFFF_FFFF);
      access(4'b0100, 32'h0000_0005, 32'h0, 3, 1'b0);
      check("lbu_value", rdata, 32'h0000_0080);
      access(4'b0010, 32'h0000_0004, 32'h0, 0, 1'b0);
      check("lw_value", rdata, 32'h1234_80FF);
      access(4'b0010, 32'h0000_0006, 32'h0, 0, 1'b0);
`ifndef LSU_MISALIGN_TRAP_EN
      check("lw_misaligned_value", rdata, 32'h1234_80FF);
`endif
      access(4'b0010, 32'h0000_0008, 32'h0, 0, 1'b1);
      access(4'b0011, 32'h0000_0008, 32'h0, 0, 1'b0);

      // start held high: exactly one more access begins from IDLE after the first done
      @(negedge clk);
      model(4'b0010, 32'h0000_0004, 32'h0, 1, 1'b0, e);
      e.end_cyc = cyc + 1 + e.req_cycles;
      q.push_back(e);
      ack_delay = 1;
      no_ack = 1'b0;
      op = 4'b0010;
      addr = 32'h0000_0004;
      start = 1'b1;
      c0 = completed;
      wait_completion(c0);
      model(4'b0010, 32'h0000_0004, 32'h0, 1, 1'b0, e);
      e.end_cyc = cyc + 2 + e.req_cycles;
      q.push_back(e);
      c0 = completed;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_completion(c0);
      @(posedge clk);
      #1;
      check_bit("held_busy_after_end", busy, 1'b0);

      // reset in the middle of a request
      @(negedge clk);
      model(4'b0010, 32'h0000_0008, 32'h0, 0, 1'b1, e);
      e.end_cyc = cyc + 1 + e.req_cycles;
      q.push_back(e);
      no_ack = 1'b1;
      op = 4'b0010;
      addr = 32'h0000_0008;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_bit("mid_req_before_reset", mem_req, 1'b1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_bit("mid_rst_mem_req", mem_req, 1'b0);
      check_bit("mid_rst_busy", busy, 1'b0);
      check_bit("mid_rst_done", done, 1'b0);
      check_bit("mid_rst_err", err, 1'b0);
      check("mid_rst_rdata", rdata, 32'h0);
      q.delete();
      model_rdata = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      no_ack = 1'b0;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 200; i++) begin
         access(4'($urandom), $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 9) == 0);
      end

      repeat (5) @(negedge clk);
      check("queue_drained", 32'(q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
